// File: rtl/sram_req_ctrl_pkg.sv
// Shared types for the SRAM request controller: FSM states, op encoding,
// statistics counter width and a saturating increment helper.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RECOVER = 3'd3,
    RESP    = 3'd4
  } sram_ctrl_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } sram_op_e;

  localparam int STAT_WIDTH = 16;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake and SRAM pin bundle between a requester,
// the sram_req_ctrl front-end and the SRAM macro.
interface sram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  chip_enable_n;
  logic                  write_enable_n;
  logic                  read_enable_n;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, data_out,
    output req_ready, rsp_valid, rsp_rdata,
           chip_enable_n, write_enable_n, read_enable_n, address, data_in
  );

  // Requester plus SRAM side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, data_out,
    input  req_ready, rsp_valid, rsp_rdata,
           chip_enable_n, write_enable_n, read_enable_n, address, data_in
  );
endinterface

// File: rtl/sram_access_timer.sv
// Loadable down-counter timing one SRAM access; o_done is high while the
// count is zero.
module sram_access_timer #(
  parameter int ACCESS_CYCLES = 2,
  parameter int CW            = $clog2(ACCESS_CYCLES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/sram_req_ctrl.sv
// Serialises single read/write requests into SRAM active-low strobes and
// returns read data on a valid/ready channel. Optional counters: SRAM_REQ_CTRL_STATS_EN.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_req_ctrl_if.slave        bus
`ifdef SRAM_REQ_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_writes,
  output logic [STAT_WIDTH-1:0] stat_reads
`endif
);

  localparam int TW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACCESS_CYCLES - 1);

  sram_ctrl_state_e      r_state;
  sram_ctrl_state_e      w_state_next;
  sram_op_e              r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_ce_n;
  logic                  r_we_n;
  logic                  r_re_n;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_timer_en;
  logic                  w_timer_done;

  sram_access_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES),
    .CW            (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_accept),
    .i_load_val (TIMER_LOAD),
    .i_en       (w_timer_en),
    .o_done     (w_timer_done)
  );

  assign w_timer_en = (r_state == WRITE) || (r_state == READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_state_next = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (w_timer_done) w_state_next = RECOVER;
      end
      READ: begin
        if (w_timer_done) begin
          w_capture    = 1'b1;
          w_state_next = RECOVER;
        end
      end
      RECOVER: begin
        w_state_next = (r_op == OP_READ) ? RESP : IDLE;
      end
      RESP: begin
        if (bus.rsp_ready) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Every output is registered off the next state so nothing combinational
  // reaches the pins, and reset lifts the strobes without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_re_n      <= 1'b1;
    end else begin
      r_req_ready <= (w_state_next == IDLE);
      r_rsp_valid <= (w_state_next == RESP);
      r_ce_n      <= !((w_state_next == WRITE) || (w_state_next == READ));
      r_we_n      <= (w_state_next != WRITE);
      r_re_n      <= (w_state_next != READ);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_READ;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_op    <= bus.req_write ? OP_WRITE : OP_READ;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_rdata <= '0;
    end else if (w_capture) begin
      r_rsp_rdata <= bus.data_out;
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.chip_enable_n  = r_ce_n;
  assign bus.write_enable_n = r_we_n;
  assign bus.read_enable_n  = r_re_n;
  assign bus.address        = r_addr;
  assign bus.data_in        = r_wdata;

`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_writes;
  logic [STAT_WIDTH-1:0] r_stat_reads;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_writes <= '0;
      r_stat_reads  <= '0;
    end else if (w_accept) begin
      if (w_state_next == WRITE) r_stat_writes <= sat_inc(r_stat_writes);
      if (w_state_next == READ)  r_stat_reads  <= sat_inc(r_stat_reads);
    end
  end

  assign stat_writes = r_stat_writes;
  assign stat_reads  = r_stat_reads;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomised bench for sram_req_ctrl: behavioural SRAM, transaction-level
// reference memory and per-cycle strobe checks.
module tb_sram_req_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int AC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [15:0] stat_writes;
  logic [15:0] stat_reads;
`endif

  sram_req_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ACCESS_CYCLES (AC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    .stat_writes (stat_writes),
    .stat_reads  (stat_reads)
`endif
  );

  // Behavioural SRAM macro driven by the controller's strobes
  logic [DW-1:0] sram_mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!bus.chip_enable_n && !bus.write_enable_n) sram_mem[bus.address] <= bus.data_in;
  end
  assign bus.data_out = (!bus.chip_enable_n && !bus.read_enable_n) ? sram_mem[bus.address] : 8'h00;

  // Transaction-level reference
  logic [DW-1:0] ref_mem [256] = '{default: 8'h00};
  int exp_writes = 0;
  int exp_reads  = 0;

  int n_vec = 0;
  int n_err = 0;
  logic run_mon = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe exclusivity, sampled every cycle outside the clock edge
  always @(negedge clk) begin
    if (run_mon) begin
      check_eq("strobe_excl", 32'(!bus.write_enable_n && !bus.read_enable_n), 32'd0);
      check_eq("strobe_no_ce", 32'((!bus.write_enable_n || !bus.read_enable_n) && bus.chip_enable_n), 32'd0);
    end
  end

  task automatic wait_ready();
    int cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("req_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [AW-1:0] churn_addr, input logic [DW-1:0] churn_data,
                           input int bp);
    logic [DW-1:0] exp_rd;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = churn_addr;
    bus.req_wdata = churn_data;
    for (int k = 1; k <= AC; k++) begin
      @(negedge clk);
      check_eq("acc_ce_n", 32'(bus.chip_enable_n), 32'd0);
      check_eq("acc_we_n", 32'(bus.write_enable_n), 32'(!wr));
      check_eq("acc_re_n", 32'(bus.read_enable_n), 32'(wr));
      check_eq("acc_addr", 32'(bus.address), 32'(addr));
      if (wr) check_eq("acc_data_in", 32'(bus.data_in), 32'(data));
      check_eq("acc_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    check_eq("rec_strobes", 32'({bus.chip_enable_n, bus.write_enable_n, bus.read_enable_n}), 32'h7);
    check_eq("rec_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    if (wr) begin
      ref_mem[addr] = data;
      exp_writes++;
      check_eq("wr_ready_again", 32'(bus.req_ready), 32'd1);
      check_eq("wr_mem", 32'(sram_mem[addr]), 32'(ref_mem[addr]));
      $display("WR addr=%02h data=%02h", addr, data);
    end else begin
      exp_rd = ref_mem[addr];
      exp_reads++;
      check_eq("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("rd_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
      for (int b = 0; b < bp; b++) begin
        @(negedge clk);
        check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("bp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_eq("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rsp_done_ready", 32'(bus.req_ready), 32'd1);
      $display("RD addr=%02h data=%02h bp=%0d", addr, exp_rd, bp);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    check_eq("rst_strobes", 32'({bus.chip_enable_n, bus.write_enable_n, bus.read_enable_n}), 32'h7);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_address", 32'(bus.address), 32'd0);
    check_eq("rst_data_in", 32'(bus.data_in), 32'd0);
    check_eq("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    reset = 1'b0;
    run_mon = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check_eq("post_rst_ce_n", 32'(bus.chip_enable_n), 32'd1);
    $display("RESET released");

    // Directed: write/read, max address, backpressure, request churn
    do_access(1'b1, 8'h00, 8'hAA, 8'($urandom), 8'($urandom), 0);
    do_access(1'b0, 8'h00, 8'h00, 8'($urandom), 8'($urandom), 0);
    do_access(1'b1, 8'hFF, 8'hFF, 8'($urandom), 8'($urandom), 0);
    do_access(1'b0, 8'hFF, 8'h00, 8'($urandom), 8'($urandom), 0);
    do_access(1'b0, 8'h00, 8'h00, 8'($urandom), 8'($urandom), 5);
    do_access(1'b1, 8'h20, 8'hCC, 8'h30, 8'hEE, 0);
    check_eq("churn_mem30", 32'(sram_mem[8'h30]), 32'(ref_mem[8'h30]));
    do_access(1'b0, 8'h20, 8'h00, 8'h30, 8'hEE, 1);

    // Random traffic over the full address range
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      if (i % 10 == 3) ra = 8'hFF;
      if (i % 10 == 7) ra = 8'h00;
      do_access(1'($urandom_range(0, 1)), ra, 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)));
    end

`ifdef SRAM_REQ_CTRL_STATS_EN
    check_eq("stat_writes", 32'(stat_writes), 32'(exp_writes));
    check_eq("stat_reads", 32'(stat_reads), 32'(exp_reads));
`endif

    // Asynchronous reset in the second WRITE cycle
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_wdata = 8'h11;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_we_n_low", 32'(bus.write_enable_n), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_strobes", 32'({bus.chip_enable_n, bus.write_enable_n, bus.read_enable_n}), 32'h7);
    check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef SRAM_REQ_CTRL_STATS_EN
    check_eq("mid_rst_stat_writes", 32'(stat_writes), 32'd0);
`endif
    exp_writes = 0;
    exp_reads  = 0;
    $display("RESET mid-access addr=40");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rec_rst_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rec_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rec_rst_address", 32'(bus.address), 32'd0);

    // Re-establish a known value at the abandoned address
    do_access(1'b1, 8'h40, 8'h5C, 8'($urandom), 8'($urandom), 0);
    do_access(1'b0, 8'h40, 8'h00, 8'($urandom), 8'($urandom), 2);
`ifdef SRAM_REQ_CTRL_STATS_EN
    check_eq("final_stat_writes", 32'(stat_writes), 32'(exp_writes));
    check_eq("final_stat_reads", 32'(stat_reads), 32'(exp_reads));
`endif

    run_mon = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
